// File: rtl/novacore_cfg_pkg.sv
// Shared definitions for the fabric configuration loader: FSM states,
// header field layout (LSB-first) and the broadcast UID marker.
package novacore_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SWITCH = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_ERR    = 3'd4
    } cfg_state_e;

    // Header layout: UID | DIM | COUNT | AUTOINC | LAST, packed from bit 0 upward.
    localparam int HDR_UID_LSB = 0;

    // All-ones UID addresses every tile; sliced down to the UID width in use.
    localparam logic [31:0] BCAST_UID = '1;

    function automatic int hdr_dim_lsb(input int uid_w);
        return HDR_UID_LSB + uid_w;
    endfunction

    function automatic int hdr_cnt_lsb(input int uid_w, input int dim_w);
        return hdr_dim_lsb(uid_w) + dim_w;
    endfunction

    function automatic int hdr_ainc_bit(input int uid_w, input int dim_w, input int cnt_w);
        return hdr_cnt_lsb(uid_w, dim_w) + cnt_w;
    endfunction

    function automatic int hdr_last_bit(input int uid_w, input int dim_w, input int cnt_w);
        return hdr_ainc_bit(uid_w, dim_w, cnt_w) + 1;
    endfunction

endpackage

// File: rtl/novacore_cfg_loader.sv
// Streams configuration frames (header, payloads, XOR trailer) into the tile
// fabric, one write strobe per payload word, and switches fabric dimension.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a frame header
// SWITCH | one-cycle dimension change before payloads (stream stalled)
// LOAD   | forwarding payload words to tiles, folding the checksum
// CHECK  | waiting for the trailer word to compare against the checksum
// ERR    | bad UID or checksum; stream stalled until reset
module novacore_cfg_loader
    import novacore_cfg_pkg::*;
#(
    parameter int GRID   = 7,
    parameter int CBUS_W = 58,
    parameter int UID_W  = 8,
    parameter int DIM_W  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CBUS_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mode,
    output logic [CBUS_W-1:0] c_bus,
    output logic [UID_W-1:0]  c_uid,
    output logic              c_clk,
    output logic [DIM_W-1:0]  c_dimension,
    output logic              c_dimswitch,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DIM_LSB  = hdr_dim_lsb(UID_W);
    localparam int CNT_LSB  = hdr_cnt_lsb(UID_W, DIM_W);
    localparam int AINC_BIT = hdr_ainc_bit(UID_W, DIM_W, CNT_W);
    localparam int LAST_BIT = hdr_last_bit(UID_W, DIM_W, CNT_W);

    localparam logic [UID_W-1:0] LAST_TILE = UID_W'(GRID * GRID - 1);
    localparam logic [UID_W-1:0] BCAST     = BCAST_UID[UID_W-1:0];

    cfg_state_e state_q, state_d;

    logic              accept;
    logic [UID_W-1:0]  hdr_uid;
    logic [DIM_W-1:0]  hdr_dim;
    logic [CNT_W-1:0]  hdr_cnt;
    logic              hdr_ainc;
    logic              hdr_last;
    logic              hdr_bad;

    logic [UID_W-1:0]  uid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ainc_q;
    logic              last_q;
    logic [DIM_W-1:0]  dim_q;
    logic [CBUS_W-1:0] csum_q;

    assign accept   = s_valid && s_ready;
    assign hdr_uid  = s_data[HDR_UID_LSB +: UID_W];
    assign hdr_dim  = s_data[DIM_LSB +: DIM_W];
    assign hdr_cnt  = s_data[CNT_LSB +: CNT_W];
    assign hdr_ainc = s_data[AINC_BIT];
    assign hdr_last = s_data[LAST_BIT];
    assign hdr_bad  = (hdr_uid > LAST_TILE) && (hdr_uid != BCAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                s_ready = 1'b1;
                if (accept) begin
                    if (hdr_bad) begin
                        state_d = ST_ERR;
                    end else if (hdr_dim != c_dimension) begin
                        state_d = ST_SWITCH;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_SWITCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                if (accept && (cnt_q == '0)) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                s_ready = 1'b1;
                if (accept) begin
                    state_d = (s_data == csum_q) ? ST_IDLE : ST_ERR;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode        <= 1'b0;
            c_bus       <= '0;
            c_uid       <= '0;
            c_clk       <= 1'b0;
            c_dimension <= '0;
            c_dimswitch <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            uid_q       <= '0;
            cnt_q       <= '0;
            ainc_q      <= 1'b0;
            last_q      <= 1'b0;
            dim_q       <= '0;
            csum_q      <= '0;
        end else begin
            c_clk       <= 1'b0;
            c_dimswitch <= 1'b0;
            done        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        mode   <= 1'b0;
                        csum_q <= '0;
                        uid_q  <= hdr_uid;
                        cnt_q  <= hdr_cnt;
                        // Broadcast frames never walk the UID.
                        ainc_q <= hdr_ainc && (hdr_uid != BCAST);
                        last_q <= hdr_last;
                        dim_q  <= hdr_dim;
                        busy   <= !hdr_bad;
                        if (hdr_bad) begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_SWITCH: begin
                    c_dimension <= dim_q;
                    c_dimswitch <= 1'b1;
                end
                ST_LOAD: begin
                    if (accept) begin
                        c_bus  <= s_data;
                        c_uid  <= uid_q;
                        c_clk  <= 1'b1;
                        csum_q <= csum_q ^ s_data;
                        if (ainc_q) begin
                            uid_q <= (uid_q == LAST_TILE) ? '0 : uid_q + UID_W'(1);
                        end
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (s_data == csum_q) begin
                            done <= 1'b1;
                            if (last_q) begin
                                mode <= 1'b1;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_novacore_cfg_loader.sv
// Bench for novacore_cfg_loader: frame-level reference model checked every
// cycle, directed frames with literal expectations, then random frames.
module tb_novacore_cfg_loader;

    localparam int NT = 49;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [57:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        mode;
    logic [57:0] c_bus;
    logic [7:0]  c_uid;
    logic        c_clk;
    logic [1:0]  c_dimension;
    logic        c_dimswitch;
    logic        busy;
    logic        done;
    logic        err;

    novacore_cfg_loader #(
        .GRID(7), .CBUS_W(58), .UID_W(8), .DIM_W(2), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .mode(mode), .c_bus(c_bus), .c_uid(c_uid), .c_clk(c_clk),
        .c_dimension(c_dimension), .c_dimswitch(c_dimswitch),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame semantics) ----------------
    bit          started = 1'b0;
    int          cyc = 0;
    logic        e_mode, e_clk, e_dsw, e_busy, e_done, e_err;
    logic [57:0] e_bus, xs;
    logic [7:0]  e_uid;
    logic [1:0]  e_dim, p_dim;
    bit          dead, sw_pend, in_frame, p_ai, p_last;
    int          remaining, m_uid;

    always @(posedge clk) begin : mdl
        logic [57:0] w;
        w = s_data;
        cyc++;
        if (rst) begin
            started = 1'b1;
            e_mode = 0; e_bus = '0; e_uid = '0; e_clk = 0; e_dim = '0; e_dsw = 0;
            e_busy = 0; e_done = 0; e_err = 0;
            dead = 0; sw_pend = 0; in_frame = 0; remaining = 0; xs = '0;
        end else if (started) begin
            e_clk = 0; e_done = 0; e_dsw = 0;
            if (!dead) begin
                if (sw_pend) begin
                    e_dim = p_dim; e_dsw = 1; sw_pend = 0;
                end else if (s_valid) begin
                    if (!in_frame) begin
                        m_uid = int'(w[7:0]);
                        p_dim = w[9:8];
                        remaining = int'(w[17:10]) + 1;
                        p_ai = w[18];
                        p_last = w[19];
                        e_mode = 0;
                        xs = '0;
                        if (m_uid >= NT && m_uid != 255) begin
                            e_err = 1; dead = 1; e_busy = 0;
                        end else begin
                            e_busy = 1; in_frame = 1;
                            if (p_dim != e_dim) sw_pend = 1;
                        end
                    end else if (remaining > 0) begin
                        e_bus = w; e_uid = 8'(m_uid); e_clk = 1;
                        xs = xs ^ w;
                        if (p_ai && m_uid != 255) m_uid = (m_uid + 1) % NT;
                        remaining--;
                    end else begin
                        in_frame = 0; e_busy = 0;
                        if (w == xs) begin
                            e_done = 1;
                            if (p_last) e_mode = 1;
                        end else begin
                            e_err = 1; dead = 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("s_ready", 64'(s_ready), 64'(!dead && !sw_pend));
            chk("mode", 64'(mode), 64'(e_mode));
            chk("c_bus", 64'(c_bus), 64'(e_bus));
            chk("c_uid", 64'(c_uid), 64'(e_uid));
            chk("c_clk", 64'(c_clk), 64'(e_clk));
            chk("c_dimension", 64'(c_dimension), 64'(e_dim));
            chk("c_dimswitch", 64'(c_dimswitch), 64'(e_dsw));
            chk("busy", 64'(busy), 64'(e_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("err", 64'(err), 64'(e_err));
        end
    end

    // ---------------- output logs for literal checks ----------------
    logic [63:0] uid_log[$];
    logic [63:0] bus_log[$];
    int dsw_count, done_count, dsw_cyc, first_cyc;

    always @(negedge clk) begin
        if (c_clk === 1'b1) begin
            uid_log.push_back(64'(c_uid));
            bus_log.push_back(64'(c_bus));
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (c_dimswitch === 1'b1) begin
            dsw_count++;
            dsw_cyc = cyc;
        end
        if (done === 1'b1) done_count++;
    end

    task automatic clr_logs();
        uid_log.delete();
        bus_log.delete();
        dsw_count = 0; done_count = 0; dsw_cyc = -1; first_cyc = -1;
    endtask

    task automatic chk_seq(input string name, input logic [63:0] got[$], input logic [63:0] exp[$]);
        chk({name, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            chk(name, (i < got.size()) ? got[i] : 64'hx, exp[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    function automatic logic [57:0] rnd_word();
        return 58'({$urandom, $urandom});
    endfunction

    function automatic logic [57:0] mk_hdr(input int uid, input int dim, input int cnt,
                                           input int ai, input int last);
        logic [57:0] h;
        h = rnd_word();
        h[7:0]   = 8'(uid);
        h[9:8]   = 2'(dim);
        h[17:10] = 8'(cnt);
        h[18]    = 1'(ai);
        h[19]    = 1'(last);
        return h;
    endfunction

    task automatic send(input logic [57:0] w, input int gap);
        logic ok;
        int budget;
        @(negedge clk);
        if (gap > 0) begin
            s_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data = w;
        budget = 0;
        forever begin
            #1;
            ok = s_ready;
            @(posedge clk);
            if (ok) break;
            budget++;
            if (budget > 60) begin
                n_checks++;
                n_err++;
                $display("FAIL send_timeout actual=stalled expected=accepted at %0t", $time);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int pick_gap(input int gapmode);
        return (gapmode < 0) ? int'($urandom_range(0, 2)) : gapmode;
    endfunction

    task automatic send_frame(input int uid, input int dim, input int cnt, input int ai,
                              input int last, input logic [57:0] pl[$],
                              input logic [57:0] tr_xor, input int gapmode);
        logic [57:0] sum;
        sum = '0;
        send(mk_hdr(uid, dim, cnt, ai, last), pick_gap(gapmode));
        foreach (pl[i]) begin
            send(pl[i], pick_gap(gapmode));
            sum = sum ^ pl[i];
        end
        send(sum ^ tr_xor, pick_gap(gapmode));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [57:0] pl[$];
        clr_logs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_mode", 64'(mode), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_c_uid", 64'(c_uid), 64'd0);
        rst = 1'b0;

        // Basic frame, constant UID, no dimension change.
        clr_logs();
        pl = '{58'h1, 58'h2, 58'h4};
        send_frame(5, 0, 2, 0, 1, pl, 58'h0, 0);
        idle(3);
        chk_seq("f1_uid", uid_log, '{64'd5, 64'd5, 64'd5});
        chk_seq("f1_bus", bus_log, '{64'h1, 64'h2, 64'h4});
        chk("f1_done", 64'(done_count), 64'd1);
        chk("f1_mode", 64'(mode), 64'd1);
        chk("f1_err", 64'(err), 64'd0);
        chk("f1_dsw", 64'(dsw_count), 64'd0);

        // Dimension switch and UID auto-increment wrapping past the last tile.
        clr_logs();
        pl = '{rnd_word(), rnd_word(), rnd_word()};
        send_frame(47, 1, 2, 1, 0, pl, 58'h0, 0);
        idle(3);
        chk_seq("f2_uid", uid_log, '{64'd47, 64'd48, 64'd0});
        chk("f2_dsw", 64'(dsw_count), 64'd1);
        chk("f2_dsw_first", 64'(dsw_cyc >= 0 && dsw_cyc < first_cyc), 64'd1);
        chk("f2_dim", 64'(c_dimension), 64'd1);
        chk("f2_mode", 64'(mode), 64'd0);
        chk("f2_done", 64'(done_count), 64'd1);

        // Broadcast: UID stays all-ones even with AUTOINC set.
        clr_logs();
        pl = '{rnd_word(), rnd_word(), rnd_word()};
        send_frame(255, 1, 2, 1, 1, pl, 58'h0, 1);
        idle(3);
        chk_seq("f3_uid", uid_log, '{64'd255, 64'd255, 64'd255});
        chk("f3_done", 64'(done_count), 64'd1);
        chk("f3_mode", 64'(mode), 64'd1);

        // Checksum mismatch: trailer 0x6 instead of 0x7.
        clr_logs();
        pl = '{58'h1, 58'h2, 58'h4};
        send_frame(5, 0, 2, 0, 1, pl, 58'h1, 0);
        idle(6);
        chk("f4_err", 64'(err), 64'd1);
        chk("f4_s_ready", 64'(s_ready), 64'd0);
        chk("f4_done", 64'(done_count), 64'd0);
        chk("f4_strobes", 64'(uid_log.size()), 64'd3);
        do_reset();

        // Out-of-range UID: error, no strobes.
        clr_logs();
        send(mk_hdr(49, 0, 2, 0, 0), 0);
        idle(5);
        chk("f5_err", 64'(err), 64'd1);
        chk("f5_strobes", 64'(uid_log.size()), 64'd0);
        chk("f5_s_ready", 64'(s_ready), 64'd0);
        do_reset();

        // Reset mid-frame after the second payload, then a clean frame.
        clr_logs();
        send(mk_hdr(3, 2, 3, 1, 1), 0);
        send(rnd_word(), 0);
        send(rnd_word(), 0);
        @(negedge clk);
        chk("f6_pre_strobe", 64'(c_clk), 64'd1);
        chk("f6_pre_dim", 64'(c_dimension), 64'd2);
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("f6_rst_mode", 64'(mode), 64'd0);
        chk("f6_rst_c_bus", 64'(c_bus), 64'd0);
        chk("f6_rst_c_uid", 64'(c_uid), 64'd0);
        chk("f6_rst_c_clk", 64'(c_clk), 64'd0);
        chk("f6_rst_dim", 64'(c_dimension), 64'd0);
        chk("f6_rst_dsw", 64'(c_dimswitch), 64'd0);
        chk("f6_rst_busy", 64'(busy), 64'd0);
        chk("f6_rst_done", 64'(done), 64'd0);
        chk("f6_rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        #1;
        chk("f6_rst_s_ready", 64'(s_ready), 64'd1);
        clr_logs();
        pl = '{rnd_word(), rnd_word()};
        send_frame(10, 0, 1, 1, 0, pl, 58'h0, 0);
        idle(3);
        chk_seq("f6_uid", uid_log, '{64'd10, 64'd11});
        chk("f6_done", 64'(done_count), 64'd1);

        // s_valid toggling every cycle through a COUNT=3 frame.
        clr_logs();
        pl = '{rnd_word(), rnd_word(), rnd_word(), rnd_word()};
        send_frame(20, 3, 3, 1, 0, pl, 58'h0, 1);
        idle(3);
        chk_seq("f7_uid", uid_log, '{64'd20, 64'd21, 64'd22, 64'd23});
        chk("f7_done", 64'(done_count), 64'd1);
        chk("f7_err", 64'(err), 64'd0);

        // Random frames against the model.
        for (int f = 0; f < 40; f++) begin
            int r, uid, cnt;
            logic [57:0] tx;
            r = int'($urandom_range(0, 19));
            if (r == 0) uid = int'($urandom_range(NT, 254));
            else if (r < 3) uid = 255;
            else uid = int'($urandom_range(0, NT - 1));
            cnt = int'($urandom_range(0, 5));
            if (uid >= NT && uid != 255) begin
                send(mk_hdr(uid, int'($urandom_range(0, 3)), cnt, 1, 1), 0);
                idle(3);
                chk("rand_bad_uid_err", 64'(err), 64'd1);
                do_reset();
            end else begin
                pl.delete();
                for (int k = 0; k <= cnt; k++) pl.push_back(rnd_word());
                tx = '0;
                if ($urandom_range(0, 9) == 0) tx[$urandom_range(0, 57)] = 1'b1;
                send_frame(uid, int'($urandom_range(0, 3)), cnt, int'($urandom_range(0, 1)),
                           int'($urandom_range(0, 1)), pl, tx, -1);
                idle(2);
                if (tx != '0) begin
                    chk("rand_bad_sum_err", 64'(err), 64'd1);
                    do_reset();
                end
            end
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
